// File: rtl/instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// instr_sequencer_if
//   Bundles the program-ROM port and the DIN/Run/Done processor handshake
//   that the instruction sequencer drives.
//
//   Signals
//     MemAddr  [AW-1:0]  ROM address (sequencer -> ROM)
//     MemData  [8:0]     ROM read data, one cycle after MemAddr (ROM -> sequencer)
//     DIN      [8:0]     instruction / immediate word (sequencer -> processor)
//     Run                issue strobe (sequencer -> processor)
//     Done               completion flag (processor -> sequencer)
//
//   Modports
//     master  : the sequencer side
//     slave   : the ROM + processor side
// ---------------------------------------------------------------------------
interface instr_sequencer_if #(
    parameter int AW = 5
);
    logic [AW-1:0] MemAddr;
    logic [8:0]    MemData;
    logic [8:0]    DIN;
    logic          Run;
    logic          Done;

    modport master (
        output MemAddr,
        output DIN,
        output Run,
        input  MemData,
        input  Done
    );

    modport slave (
        input  MemAddr,
        input  DIN,
        input  Run,
        output MemData,
        output Done
    );
endinterface

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Initiator side of the processor's DIN/Run/Done instruction interface.
//   Walks a synchronous program ROM from address 0, presents each 9-bit word
//   (iiixxxyyy) on DIN, pulses Run for one cycle and waits for Done before
//   retiring it. MVI occupies two ROM words: the instruction, then the
//   immediate, which is placed on DIN in the cycle after the Run pulse.
//   Opcode 111 ends the program; running past PROG_LEN also ends it.
//
//   Parameters
//     AW        ROM address width
//     PROG_LEN  number of valid program words (2 .. 2**AW)
//     TIMEOUT   WAIT cycles allowed for Done before flagging an error
//
//   Ports
//     Clock       rising-edge clock
//     Resetn      asynchronous active-low reset
//     Start       start / restart request (level, ignored while Busy)
//     bus         master side of instr_sequencer_if (ROM + processor)
//     Busy        high in every state except IDLE / HALTED / ERROR
//     Halted      program ended normally (held until the next Start)
//     Error       Done timeout or MVI in the last program word (held)
//     InstrCount  retired instructions, 8-bit wrapping
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int AW       = 5,
    parameter int PROG_LEN = 32,
    parameter int TIMEOUT  = 15
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                Start,
    instr_sequencer_if.master   bus,
    output logic                Busy,
    output logic                Halted,
    output logic                Error,
    output logic [7:0]          InstrCount
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [3:0] {
        IDLE,
        FETCH_I,
        LOAD_I,
        FETCH_D,
        LOAD_D,
        PRESENT,
        ISSUE,
        IMM,
        WAIT,
        HALTED,
        ERROR
    } state_t;

    state_t          state_reg,    state_next;
    // One bit wider than the ROM address so PC+2 past the end is never
    // mistaken for a small address.
    logic [AW:0]     pc_reg,       pc_next;
    logic [AW-1:0]   mem_addr_reg, mem_addr_next;
    logic [8:0]      din_reg,      din_next;
    logic            run_reg,      run_next;
    logic [8:0]      instr_reg,    instr_next;
    logic [8:0]      imm_reg,      imm_next;
    logic [TW-1:0]   timer_reg,    timer_next;
    logic [7:0]      count_reg,    count_next;

    logic            instr_is_mvi;

    assign instr_is_mvi = (instr_reg[8:6] == OP_MVI);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg    <= IDLE;
            pc_reg       <= '0;
            mem_addr_reg <= '0;
            din_reg      <= '0;
            run_reg      <= 1'b0;
            instr_reg    <= '0;
            imm_reg      <= '0;
            timer_reg    <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            mem_addr_reg <= mem_addr_next;
            din_reg      <= din_next;
            run_reg      <= run_next;
            instr_reg    <= instr_next;
            imm_reg      <= imm_next;
            timer_reg    <= timer_next;
            count_reg    <= count_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        mem_addr_next = mem_addr_reg;
        din_next      = din_reg;
        run_next      = 1'b0;
        instr_next    = instr_reg;
        imm_next      = imm_reg;
        timer_next    = timer_reg;
        count_next    = count_reg;

        unique case (state_reg)
            IDLE, HALTED, ERROR: begin
                if (Start) begin
                    pc_next    = '0;
                    count_next = '0;
                    state_next = FETCH_I;
                end
            end

            FETCH_I: begin
                state_next = LOAD_I;
            end

            LOAD_I: begin
                instr_next = bus.MemData;
                if (bus.MemData[8:6] == OP_HALT) begin
                    state_next = HALTED;
                end else if (bus.MemData[8:6] == OP_MVI) begin
                    // The immediate would lie outside the program.
                    if (pc_reg == (AW+1)'(PROG_LEN - 1)) begin
                        state_next = ERROR;
                    end else begin
                        state_next = FETCH_D;
                    end
                end else begin
                    state_next = PRESENT;
                end
            end

            FETCH_D: begin
                state_next = LOAD_D;
            end

            LOAD_D: begin
                imm_next   = bus.MemData;
                state_next = PRESENT;
            end

            PRESENT: begin
                state_next = ISSUE;
            end

            ISSUE: begin
                timer_next = '0;
                state_next = instr_is_mvi ? IMM : WAIT;
            end

            IMM: begin
                timer_next = '0;
                state_next = WAIT;
            end

            WAIT: begin
                // timer_reg counts completed WAIT cycles. A zero value marks
                // the first WAIT cycle, where Done may still be left over
                // from the previous instruction and is not trusted.
                if ((timer_reg != '0) && bus.Done) begin
                    count_next = count_reg + 8'd1;
                    pc_next    = pc_reg + (instr_is_mvi ? (AW+1)'(2) : (AW+1)'(1));
                    if (pc_next >= (AW+1)'(PROG_LEN)) begin
                        state_next = HALTED;
                    end else begin
                        state_next = FETCH_I;
                    end
                end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                    // This was WAIT cycle number TIMEOUT: the timer would
                    // reach TIMEOUT without a completion.
                    state_next = ERROR;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Registered outputs are loaded from the upcoming state so that the
        // ROM address is already on MemAddr during FETCH_*, and DIN/Run are
        // valid during PRESENT/ISSUE/IMM themselves.
        if (state_next == FETCH_I) begin
            mem_addr_next = pc_next[AW-1:0];
        end else if (state_next == FETCH_D) begin
            mem_addr_next = pc_reg[AW-1:0] + AW'(1);
        end

        if (state_next == PRESENT) begin
            din_next = instr_next;
        end else if (state_next == IMM) begin
            din_next = imm_reg;
        end

        run_next = (state_next == ISSUE);
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.MemAddr = mem_addr_reg;
    assign bus.DIN     = din_reg;
    assign bus.Run     = run_reg;

    assign Busy       = !((state_reg == IDLE) || (state_reg == HALTED) || (state_reg == ERROR));
    assign Halted     = (state_reg == HALTED);
    assign Error      = (state_reg == ERROR);
    assign InstrCount = count_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//   Random and directed programs are loaded into a behavioural ROM. A
//   reference model walks each program with plain arithmetic, pushing every
//   expected issued word (with its expected Run cycle) into a scoreboard
//   queue and the processor's completion delays into a second queue. A
//   monitor pops and compares whenever Run is seen; the driver checks the
//   end-of-program flags, counter and end cycle.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

    localparam int AW       = 3;
    localparam int PROG_LEN = 8;
    localparam int TIMEOUT  = 15;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       Start = 1'b0;
    logic       Busy, Halted, Error;
    logic [7:0] InstrCount;

    instr_sequencer_if #(.AW(AW)) bus ();

    instr_sequencer #(
        .AW       (AW),
        .PROG_LEN (PROG_LEN),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .Start      (Start),
        .bus        (bus),
        .Busy       (Busy),
        .Halted     (Halted),
        .Error      (Error),
        .InstrCount (InstrCount)
    );

    always #5 Clock = ~Clock;

    // Synchronous program ROM
    logic [8:0] rom [PROG_LEN];
    always @(posedge Clock) bus.MemData <= rom[bus.MemAddr];

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        logic [8:0] word;
        int         t;
    } exp_t;

    exp_t exp_q[$];
    int   delay_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   ref_cyc = 0;
    bit   done_stuck = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    function automatic int pick_delay();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return 15;
        if (r == 1) return 16;
        if (r == 2) return 17;
        return $urandom_range(1, 6);
    endfunction

    // Reference model. Times are cycles after the cycle in which Start is
    // sampled. Per instruction: fetch+decode take 2 cycles, MVI fetches its
    // immediate in 2 more, then one setup cycle and the Run cycle; MVI adds
    // one immediate cycle; WAIT cycle k is when completion may be taken
    // (k >= 2), and the next fetch begins the cycle after.
    task automatic build_model(input int force_d, input bit stuck, output int end_t,
                               output int exp_cnt, output bit exp_halt, output bit exp_err);
        int         pc, t, d, wc, issue, wbase;
        logic [8:0] w;
        bit         mvi;
        pc = 0; t = 0;
        exp_cnt = 0; exp_halt = 1'b0; exp_err = 1'b0; end_t = 0;
        exp_q.delete();
        delay_q.delete();
        while (1) begin
            w   = rom[pc];
            mvi = (w[8:6] == 3'b001);
            if (w[8:6] == 3'b111) begin
                exp_halt = 1'b1; end_t = t + 3; break;
            end
            if (mvi && pc == PROG_LEN - 1) begin
                exp_err = 1'b1; end_t = t + 3; break;
            end
            issue = t + (mvi ? 6 : 4);
            exp_q.push_back('{w, issue});
            if (mvi) exp_q.push_back('{rom[pc + 1], issue + 1});
            wbase = issue + (mvi ? 1 : 0);
            d = (force_d > 0) ? force_d : pick_delay();
            delay_q.push_back(d);
            // Done rises d cycles after the Run cycle and stays high.
            wc = stuck ? 2 : (d - (mvi ? 1 : 0));
            if (wc < 2) wc = 2;
            if (wc > TIMEOUT) begin
                exp_err = 1'b1; end_t = wbase + TIMEOUT + 1; break;
            end
            exp_cnt = (exp_cnt + 1) % 256;
            pc += mvi ? 2 : 1;
            if (pc >= PROG_LEN) begin
                exp_halt = 1'b1; end_t = wbase + wc + 1; break;
            end
            t = wbase + wc;
        end
    endtask

    // Processor responder: raises Done a chosen number of cycles after each
    // Run pulse and keeps it high until the next Run.
    initial begin
        int done_cnt;
        bit done_hold;
        done_cnt  = 0;
        done_hold = 1'b0;
        bus.Done  = 1'b0;
        forever begin
            @(negedge Clock);
            if (bus.Run === 1'b1) begin
                done_cnt  = (delay_q.size() > 0) ? delay_q.pop_front() : 1;
                done_hold = 1'b0;
            end else if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) done_hold = 1'b1;
            end
            bus.Done = done_stuck | done_hold;
        end
    end

    // Scoreboard monitor
    initial begin
        exp_t       e;
        bit         imm_due;
        logic [8:0] imm_word;
        imm_due = 1'b0;
        imm_word = '0;
        forever begin
            @(negedge Clock);
            if (!Resetn) begin
                imm_due = 1'b0;
            end else if (imm_due) begin
                imm_due = 1'b0;
                check("imm_run_low", 32'(bus.Run), 32'd0);
                check("imm_din", 32'(bus.DIN), 32'(imm_word));
            end else if (bus.Run !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("run_without_expectation", 32'(bus.Run), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_din", 32'(bus.DIN), 32'(e.word));
                    check("issue_cycle", 32'(cyc - ref_cyc), 32'(e.t));
                    if (e.word[8:6] == 3'b001 && exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        imm_word = e.word;
                        imm_due  = 1'b1;
                    end
                end
            end
        end
    end

    task automatic run_program(input string tag, input int force_d, input bit stuck, input bit hold_start);
        int end_t, exp_cnt, n_issue;
        bit eh, ee;
        build_model(force_d, stuck, end_t, exp_cnt, eh, ee);
        n_issue = exp_q.size();
        @(negedge Clock);
        done_stuck = stuck;
        Start   = 1'b1;
        ref_cyc = cyc;
        @(negedge Clock);
        check({tag, ":busy_after_start"}, 32'(Busy), 32'd1);
        check({tag, ":flags_cleared"}, 32'({Halted, Error}), 32'd0);
        check({tag, ":count_cleared"}, 32'(InstrCount), 32'd0);
        if (!hold_start) Start = 1'b0;
        while (cyc < ref_cyc + end_t - 1) @(negedge Clock);
        check({tag, ":busy_before_end"}, 32'(Busy), 32'd1);
        @(negedge Clock);
        check({tag, ":busy_at_end"}, 32'(Busy), 32'd0);
        check({tag, ":halted"}, 32'(Halted), 32'(eh));
        check({tag, ":error"}, 32'(Error), 32'(ee));
        check({tag, ":instr_count"}, 32'(InstrCount), 32'(exp_cnt));
        check({tag, ":all_issued"}, 32'(exp_q.size()), 32'd0);
        Start = 1'b0;
        $display("program %-12s words=%0d retired=%0d halted=%0d error=%0d cycles=%0d",
                 tag, n_issue, InstrCount, Halted, Error, end_t);
        @(negedge Clock);
        done_stuck = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ":mem_addr"}, 32'(bus.MemAddr), 32'd0);
        check({tag, ":din"}, 32'(bus.DIN), 32'd0);
        check({tag, ":run"}, 32'(bus.Run), 32'd0);
        check({tag, ":busy"}, 32'(Busy), 32'd0);
        check({tag, ":halted"}, 32'(Halted), 32'd0);
        check({tag, ":error"}, 32'(Error), 32'd0);
        check({tag, ":count"}, 32'(InstrCount), 32'd0);
    endtask

    // Reset in the middle of a program: MV at word 0 whose Done never comes.
    task automatic reset_during(input bit in_issue);
        int end_t, exp_cnt;
        bit eh, ee;
        rom[0] = 9'b000_001_010;
        rom[1] = 9'b011_010_001;
        rom[2] = 9'b111_000_000;
        build_model(1000, 1'b0, end_t, exp_cnt, eh, ee);
        @(negedge Clock);
        Start   = 1'b1;
        ref_cyc = cyc;
        @(negedge Clock);
        Start = 1'b0;
        if (in_issue) begin
            while (cyc < ref_cyc + 3) @(negedge Clock);
            @(posedge Clock);
            #2;
            check("pre_reset_run", 32'(bus.Run), 32'd1);
        end else begin
            while (cyc < ref_cyc + 7) @(negedge Clock);
            #1;
        end
        Resetn = 1'b0;
        #1;
        check_reset_values(in_issue ? "reset_in_issue" : "reset_in_wait");
        @(negedge Clock);
        Resetn = 1'b1;
        exp_q.delete();
        delay_q.delete();
        $display("program %-12s aborted by reset", in_issue ? "rst_issue" : "rst_wait");
        run_program(in_issue ? "rerun_issue" : "rerun_wait", 1, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < PROG_LEN; i++) rom[i] = 9'b111_000_000;
        repeat (3) @(negedge Clock);
        check_reset_values("power_on_reset");
        Resetn = 1'b1;
        @(negedge Clock);

        // MV then HALT with Done tied high
        rom[0] = 9'b000_001_010;
        rom[1] = 9'b111_000_000;
        run_program("mv_halt", 0, 1'b1, 1'b0);

        // MVI with immediate, then HALT
        rom[0] = 9'b001_011_000;
        rom[1] = 9'h1A5;
        rom[2] = 9'b111_000_000;
        run_program("mvi_halt", 0, 1'b0, 1'b0);

        // ADD with no Done, then restart from ERROR
        rom[0] = 9'b010_000_001;
        rom[1] = 9'b111_000_000;
        run_program("add_timeout", 1000, 1'b0, 1'b0);
        run_program("restart_ok", 3, 1'b0, 1'b0);

        // Done on the last allowed WAIT cycle, and one cycle later
        run_program("done_at_15", 15, 1'b0, 1'b0);
        run_program("done_at_16", 16, 1'b0, 1'b0);

        // MVI in the last program word
        for (int i = 0; i < PROG_LEN - 1; i++) rom[i] = 9'(i);
        rom[PROG_LEN - 1] = 9'b001_111_000;
        run_program("mvi_last", 0, 1'b0, 1'b0);

        // Plain MVs filling the whole program, no HALT
        rom[PROG_LEN - 1] = 9'b000_111_110;
        run_program("run_off_end", 0, 1'b0, 1'b0);

        // Done stuck high and Start held high throughout
        rom[0] = 9'b010_001_010;
        rom[1] = 9'b001_100_000;
        rom[2] = 9'h0F3;
        rom[3] = 9'b011_100_001;
        rom[4] = 9'b111_000_000;
        run_program("stuck_hold", 0, 1'b1, 1'b1);

        reset_during(1'b0);
        reset_during(1'b1);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < PROG_LEN; i++) rom[i] = 9'($urandom);
            run_program($sformatf("random_%0d", n), 0, ($urandom_range(0, 4) == 0), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
